// File: rtl/display_scan_driver.sv
// display_scan_driver
// Multiplexes NUM_DIGITS BCD digits onto one 7-segment bus.
// Each frame of digits is decoded from a snapshot of bcd_in taken at the start of the frame,
// so a value that changes partway through a frame is never shown torn across digits.
// Segments are still driven during the blank window at the start of each slot. Only dig_sel is
// held off in that window, so the segment lines settle before the next digit is enabled.

module display_scan_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit DIG_ACT_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);

  localparam logic [7:0]            SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACT_LOW}};

  logic [CW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_done_q, frame_done_d;

  logic                    scan_wrap;
  logic                    frame_end;
  logic                    snap_load;
  logic [4*NUM_DIGITS-1:0] snap_view;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    upper_zero;
  logic                    dark;
  logic [7:0]              seg_act;
  logic [NUM_DIGITS-1:0]   dig_act;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign scan_wrap = (scan_cnt_q == SCAN_LAST);
  assign frame_end = en && scan_wrap && (idx_q == IDX_LAST);
  assign snap_load = en && (idx_q == '0) && (scan_cnt_q == '0);
  // The slot that captures the snapshot already shows the captured value.
  assign snap_view = snap_load ? bcd_in : snap_q;

  // Scan position, blink timebase and frame snapshot: next-state logic.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    snap_d      = snap_q;
    if (en) begin
      if (scan_wrap) begin
        scan_cnt_d = '0;
        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + 1'b1;
      end
    end
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (snap_load) begin
      snap_d = bcd_in;
    end
  end

  // Select the active digit and work out whether every digit from it up to the top is zero.
  always_comb begin
    cur_bcd    = 4'd0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (int'(idx_q) == d) begin
        cur_bcd   = snap_view[4*d +: 4];
        cur_dp    = dp_in[d];
        cur_blink = blink_mask[d];
      end
      if ((d >= int'(idx_q)) && (snap_view[4*d +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Build the output pattern for the current slot. Polarity is applied last.
  always_comb begin
    dark    = (cur_blink && blink_ph_q) || (lz_blank && (idx_q != '0) && upper_zero);
    seg_act = dark ? 8'h00 : {cur_dp, seg_decode(cur_bcd)};
    dig_act = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dig_act[d] = (int'(idx_q) == d) && (scan_cnt_q >= BLANK_END);
    end
    seg_d        = SEG_OFF;
    dig_d        = DIG_OFF;
    frame_done_d = 1'b0;
    if (en) begin
      seg_d        = seg_act ^ SEG_OFF;
      dig_d        = dig_act ^ DIG_OFF;
      frame_done_d = frame_end;
    end
  end

  // State and output registers. Reset puts every output at its inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      snap_q       <= '0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      snap_q       <= snap_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Testbench for display_scan_driver. A normal-polarity instance and an inverted-polarity
// instance share the same inputs. Expected slot outputs for each frame are queued when the
// frame's stimulus is applied, and are popped one per clock as the DUT produces them.

module tb_display_scan_driver;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [4*ND-1:0] bcd_in;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] blink_mask;
  logic          lz_blank;
  logic [7:0]    seg_out, seg_inv;
  logic [ND-1:0] dig_sel, dig_inv;
  logic          frame_done, fd_inv;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  typedef struct packed {
    logic [ND-1:0] dig;
    logic [7:0]    seg;
    logic          fd;
  } exp_t;

  exp_t sb_q[$];

  display_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
    .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  display_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) u_inv (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank),
    .seg_out(seg_inv), .dig_sel(dig_inv), .frame_done(fd_inv)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Plays one full frame. Inputs are applied just after the previous frame's last output,
  // so they are in place before this frame's snapshot edge. chg_at replaces bcd_in after that
  // slot position has been seen. pause_at drops en for 5 cycles before that position.
  task automatic run_frame(input logic [4*ND-1:0] bcd, input logic [ND-1:0] dp,
                           input logic [ND-1:0] bm, input logic lz,
                           input int chg_at, input logic [4*ND-1:0] chg_bcd,
                           input int pause_at);
    exp_t e;
    logic ph, dark, upper0;
    int i, c;
    bcd_in = bcd; dp_in = dp; blink_mask = bm; lz_blank = lz;
    ph = ((frame_no / BF) % 2) == 1;
    for (int p = 0; p < ND*SD; p++) begin
      i = p / SD;
      c = p % SD;
      upper0 = 1'b1;
      for (int d = i; d < ND; d++) if (bcd[4*d +: 4] != 4'd0) upper0 = 1'b0;
      dark  = (bm[i] && ph) || (lz && (i > 0) && upper0);
      e.dig = (c >= BC) ? ND'(1 << i) : '0;
      e.seg = dark ? 8'h00 : {dp[i], ref_seg(bcd[4*i +: 4])};
      e.fd  = (p == ND*SD-1);
      sb_q.push_back(e);
    end
    for (int p = 0; p < ND*SD; p++) begin
      if (p == pause_at) begin
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          n_checks++;
          if ({dig_sel, seg_out, frame_done} !== {{ND{1'b0}}, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL pause_dark f%0d k%0d: got dig=%b seg=%h fd=%b, expected all off",
                     frame_no, k, dig_sel, seg_out, frame_done);
          end
          n_checks++;
          if ({dig_inv, seg_inv} !== {{ND{1'b1}}, 8'hFF}) begin
            n_fail++;
            $display("FAIL pause_dark_inv f%0d k%0d: got dig=%b seg=%h, expected 111111/ff",
                     frame_no, k, dig_inv, seg_inv);
          end
        end
        en = 1'b1;
      end
      @(posedge clk); #1;
      if (p == chg_at) bcd_in = chg_bcd;
      e = sb_q.pop_front();
      n_checks++;
      if (dig_sel !== e.dig) begin
        n_fail++;
        $display("FAIL dig_sel f%0d p%0d: got %b expected %b", frame_no, p, dig_sel, e.dig);
      end
      n_checks++;
      if (seg_out !== e.seg) begin
        n_fail++;
        $display("FAIL seg_out f%0d p%0d: got %h expected %h", frame_no, p, seg_out, e.seg);
      end
      n_checks++;
      if (frame_done !== e.fd) begin
        n_fail++;
        $display("FAIL frame_done f%0d p%0d: got %b expected %b", frame_no, p, frame_done, e.fd);
      end
      n_checks++;
      if ({dig_inv, seg_inv} !== ~{e.dig, e.seg}) begin
        n_fail++;
        $display("FAIL inverted f%0d p%0d: got dig=%b seg=%h expected dig=%b seg=%h",
                 frame_no, p, dig_inv, seg_inv, ~e.dig, ~e.seg);
      end
    end
    frame_no++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; bcd_in = '0; dp_in = '0; blink_mask = '0; lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({dig_sel, seg_out, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got dig=%b seg=%h fd=%b expected zeros", dig_sel, seg_out, frame_done);
    end
    rst = 1'b0; en = 1'b1; bcd_in = 24'h123456;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({dig_sel, seg_out, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got dig=%b seg=%h fd=%b expected zeros", dig_sel, seg_out, frame_done);
    end
    n_checks++;
    if ({dig_inv, seg_inv, fd_inv} !== {{ND{1'b1}}, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async_inv: got dig=%b seg=%h fd=%b expected 111111/ff/0",
               dig_inv, seg_inv, fd_inv);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(24'h123456, '0, '0, 1'b0, -1, '0, -1);
  endtask

  task automatic test_scan();
    run_frame(24'h123456, '0, '0, 1'b0, -1, '0, -1);
    run_frame(24'h123456, '0, '0, 1'b0, -1, '0, -1);
  endtask

  task automatic test_snapshot();
    run_frame(24'h123456, '0, '0, 1'b0, 12, 24'h999999, -1);
    run_frame(24'h999999, '0, '0, 1'b0, -1, '0, -1);
  endtask

  task automatic test_leading_zero();
    run_frame(24'h000070, '0, '0, 1'b1, -1, '0, -1);
    run_frame(24'h000000, '0, '0, 1'b1, -1, '0, -1);
  endtask

  task automatic test_blink();
    for (int f = 0; f < 4; f++) run_frame(24'h123456, '0, 6'b000011, 1'b0, -1, '0, -1);
  endtask

  task automatic test_invalid_dp();
    run_frame(24'hFEDCBA, 6'b001001, '0, 1'b0, -1, '0, -1);
    run_frame(24'h12345A, 6'b000001, '0, 1'b1, -1, '0, -1);
  endtask

  task automatic test_enable();
    run_frame(24'h654321, 6'b100000, '0, 1'b0, -1, '0, 10);
  endtask

  task automatic test_back_to_back();
    run_frame(24'h000100, '0, 6'b100100, 1'b1, -1, '0, -1);
    run_frame(24'h000100, '0, 6'b100100, 1'b1, -1, '0, -1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_leading_zero();
    test_blink();
    test_invalid_dp();
    test_enable();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
